// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch unit and its queue.
// Instruction/address paths, FSM states, queue entry.
package fetch_unit_pkg;

  typedef logic [31:0] InsnPath;
  typedef logic [31:0] InsnAddrPath;

  localparam InsnAddrPath INSN_PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } FetchState;

  typedef struct packed {
    InsnPath     insn;
    InsnAddrPath pc;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch FIFO with synchronous flush.
// Push and pop may coincide at any occupancy.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  FetchQueueEntry             pushEntry,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output FetchQueueEntry             head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  FetchQueueEntry mem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [PW:0]   cnt;
  logic          doPush;
  logic          doPop;

  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign head   = mem[headPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Pointers wrap naturally: depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      cnt     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      cnt     <= '0;
    end else begin
      if (doPush) begin
        mem[tailPtr] <= pushEntry;
        tailPtr      <= tailPtr + 1'b1;
      end
      if (doPop) begin
        headPtr <= headPtr + 1'b1;
      end
      cnt <= cnt + {{PW{1'b0}}, doPush}
                 - {{PW{1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC, one-outstanding imem handshake,
// redirect flush with stale-response drain.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter InsnAddrPath RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brRedirect,
  input  logic [31:0] brTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic        insnValid,
  output logic [31:0] insn,
  output logic [31:0] insnPC,
  input  logic        insnReady
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(QUEUE_DEPTH);

  FetchState      state;
  FetchState      stateNext;
  InsnAddrPath    pc;
  InsnAddrPath    pcNext;
  InsnAddrPath    reqPC;
  InsnAddrPath    reqPCNext;
  logic           hs;
  logic           push;
  logic           pop;
  logic           qFull;
  logic           qEmpty;
  logic [CW-1:0]  qCount;
  FetchQueueEntry qHead;
  FetchQueueEntry qIn;

  assign imemAddr  = pc;
  assign insnValid = !qEmpty;
  assign insn      = qHead.insn;
  assign insnPC    = qHead.pc;
  assign pop       = insnValid && insnReady && !brRedirect;
  assign qIn       = '{insn: imemRspData, pc: reqPC};

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) uQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushEntry(qIn),
    .pop      (pop),
    .flush    (brRedirect),
    .full     (qFull),
    .empty    (qEmpty),
    .count    (qCount),
    .head     (qHead)
  );

  // Next-state, request and enqueue decisions; redirect overrides.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    reqPCNext = reqPC;
    imemReq   = 1'b0;
    hs        = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        imemReq = (qCount < DEPTH_CNT);
        hs      = imemReq && imemGnt;
        if (hs) begin
          reqPCNext = pc;
          pcNext    = pc + INSN_PC_INC;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imemRspValid) begin
          push      = !qFull;
          stateNext = REQ;
        end
      end
      DRAIN: begin
        if (imemRspValid) stateNext = REQ;
      end
      default: stateNext = IDLE;
    endcase
    if (brRedirect) begin
      pcNext = brTarget;
      push   = 1'b0;
      unique case (state)
        IDLE:    stateNext = REQ;
        REQ:     stateNext = hs ? DRAIN : REQ;
        WAIT:    stateNext = imemRspValid ? REQ : DRAIN;
        DRAIN:   stateNext = imemRspValid ? REQ : DRAIN;
        default: stateNext = IDLE;
      endcase
    end
  end

  // State, PC and in-flight request PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      reqPC <= RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      reqPC <= reqPCNext;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus
// backpressure and mid-WAIT reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        brRedirect;
  logic [31:0] brTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        insnValid;
  logic [31:0] insn;
  logic [31:0] insnPC;
  logic        insnReady;

  int nVec = 0;
  int nMis = 0;

  fetch_unit #(
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .brRedirect  (brRedirect),
    .brTarget    (brTarget),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemGnt     (imemGnt),
    .imemRspValid(imemRspValid),
    .imemRspData (imemRspData),
    .insnValid   (insnValid),
    .insn        (insn),
    .insnPC      (insnPC),
    .insnReady   (insnReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rsp;
    logic [31:0] data;
    logic        rdy;
    logic        eReq;
    logic        ca;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInsn;
    logic [31:0] ePC;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic b, input logic [31:0] t,
    input logic g, input logic rs, input logic [31:0] d,
    input logic rd, input logic eq, input logic c,
    input logic [31:0] ea, input logic ev,
    input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.br = b; v.tgt = t; v.gnt = g;
    v.rsp = rs; v.data = d; v.rdy = rd;
    v.eReq = eq; v.ca = c; v.eAddr = ea;
    v.eValid = ev; v.eInsn = ei; v.ePC = ep;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reactive memory model state
  logic        pend = 1'b0;
  logic [31:0] pendAddr = '0;
  logic        sReq, sValid, sDeq;
  logic [31:0] sAddr, sInsn, sPC;

  task automatic memCycle(input logic r,
                          input logic g,
                          input logic rd);
    @(negedge clk);
    rst          = r;
    brRedirect   = 1'b0;
    brTarget     = '0;
    imemGnt      = g;
    insnReady    = rd;
    imemRspValid = pend;
    imemRspData  = 32'hA0 + (pendAddr >> 2);
    #1;
    sReq   = imemReq;
    sAddr  = imemAddr;
    sValid = insnValid;
    sInsn  = insn;
    sPC    = insnPC;
    sDeq   = insnValid && rd && !r;
    pend     = imemReq && g && !r;
    pendAddr = imemAddr;
  endtask

  vec_t vecs [25];

  initial begin
    int got;
    int hsCnt;
    int cyc;
    logic seenReq;
    rst = 1'b1;
    brRedirect = 1'b0; brTarget = '0;
    imemGnt = 1'b0; imemRspValid = 1'b0;
    imemRspData = '0; insnReady = 1'b0;

    // reset, stream, redirects in WAIT / REQ+gnt /
    // WAIT+rsp / REQ without gnt
    vecs[0]  = mk(1,0,0,0,0,0,0, 0,1,0, 0,0,0);
    vecs[1]  = mk(1,0,0,0,0,0,0, 0,1,0, 0,0,0);
    vecs[2]  = mk(1,0,0,0,0,0,0, 0,1,0, 0,0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0, 0,1,0, 0,0,0);
    vecs[4]  = mk(0,0,0,1,0,0,1, 1,1,32'h0, 0,0,0);
    vecs[5]  = mk(0,0,0,1,1,32'hA0,1, 0,0,0, 0,0,0);
    vecs[6]  = mk(0,0,0,1,0,0,1, 1,1,32'h4, 1,32'hA0,32'h0);
    vecs[7]  = mk(0,0,0,1,1,32'hA1,1, 0,0,0, 0,0,0);
    vecs[8]  = mk(0,0,0,1,0,0,1, 1,1,32'h8, 1,32'hA1,32'h4);
    vecs[9]  = mk(0,1,32'h100,0,0,0,1, 0,0,0, 0,0,0);
    vecs[10] = mk(0,0,0,1,0,0,1, 0,0,0, 0,0,0);
    vecs[11] = mk(0,0,0,1,1,32'hA2,1, 0,0,0, 0,0,0);
    vecs[12] = mk(0,0,0,1,0,0,1, 1,1,32'h100, 0,0,0);
    vecs[13] = mk(0,0,0,1,1,32'hB0,1, 0,0,0, 0,0,0);
    vecs[14] = mk(0,1,32'h200,1,0,0,1,
                  1,1,32'h104, 1,32'hB0,32'h100);
    vecs[15] = mk(0,0,0,1,1,32'hC0,1, 0,0,0, 0,0,0);
    vecs[16] = mk(0,0,0,1,0,0,1, 1,1,32'h200, 0,0,0);
    vecs[17] = mk(0,1,32'h300,1,1,32'hD0,1, 0,0,0, 0,0,0);
    vecs[18] = mk(0,0,0,0,0,0,1, 1,1,32'h300, 0,0,0);
    vecs[19] = mk(0,1,32'h400,0,0,0,1, 1,1,32'h300, 0,0,0);
    vecs[20] = mk(0,0,0,1,0,0,1, 1,1,32'h400, 0,0,0);
    vecs[21] = mk(0,0,0,1,1,32'hE0,1, 0,0,0, 0,0,0);
    vecs[22] = mk(0,0,0,0,0,0,0,
                  1,1,32'h404, 1,32'hE0,32'h400);
    vecs[23] = mk(0,0,0,0,0,0,1,
                  1,1,32'h404, 1,32'hE0,32'h400);
    vecs[24] = mk(0,0,0,0,0,0,1, 1,1,32'h404, 0,0,0);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      brRedirect   = vecs[i].br;
      brTarget     = vecs[i].tgt;
      imemGnt      = vecs[i].gnt;
      imemRspValid = vecs[i].rsp;
      imemRspData  = vecs[i].data;
      insnReady    = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d imemReq", i), 32'(imemReq), 32'(vecs[i].eReq));
      if (vecs[i].ca)
        chk($sformatf("v%0d imemAddr", i), imemAddr, vecs[i].eAddr);
      chk($sformatf("v%0d insnValid", i), 32'(insnValid), 32'(vecs[i].eValid));
      if (vecs[i].eValid || vecs[i].rst) begin
        chk($sformatf("v%0d insn", i), insn, vecs[i].eInsn);
        chk($sformatf("v%0d insnPC", i), insnPC, vecs[i].ePC);
      end
    end

    // backpressure: fill queue, stall, then drain
    pend = 1'b0;
    repeat (3) memCycle(1, 0, 0);
    repeat (20) memCycle(0, 1, 0);
    chk("bp stallReq", 32'(sReq), 32'd0);
    chk("bp stallAddr", sAddr, 32'h10);
    chk("bp headValid", 32'(sValid), 32'd1);
    chk("bp headPC", sPC, 32'h0);
    chk("bp headInsn", sInsn, 32'hA0);
    got = 0;
    seenReq = 1'b0;
    cyc = 0;
    while (cyc < 60 && got < 6) begin
      memCycle(0, 1, 1);
      if (sReq && !seenReq) begin
        seenReq = 1'b1;
        chk("bp resumeAddr", sAddr, 32'h10);
      end
      if (sDeq) begin
        chk($sformatf("bp deqPC%0d", got), sPC, 32'(got * 4));
        chk($sformatf("bp deqInsn%0d", got), sInsn, 32'hA0 + 32'(got));
        got++;
      end
      cyc++;
    end
    chk("bp deqCount", 32'(got), 32'd6);

    // reset mid-WAIT with 3 queued, response during reset
    pend = 1'b0;
    repeat (3) memCycle(1, 0, 0);
    hsCnt = 0;
    cyc = 0;
    while (cyc < 30 && hsCnt < 4) begin
      memCycle(0, 1, 0);
      if (pend) hsCnt++;
      cyc++;
    end
    chk("rw hsCount", 32'(hsCnt), 32'd4);
    chk("rw preValid", 32'(sValid), 32'd1);
    memCycle(1, 1, 0);
    chk("rw rstValid", 32'(sValid), 32'd0);
    chk("rw rstReq", 32'(sReq), 32'd0);
    chk("rw rstAddr", sAddr, 32'h0);
    chk("rw rstInsn", sInsn, 32'h0);
    repeat (2) memCycle(1, 1, 0);
    memCycle(0, 1, 1);
    chk("rw idleReq", 32'(sReq), 32'd0);
    chk("rw idleValid", 32'(sValid), 32'd0);
    memCycle(0, 1, 1);
    chk("rw firstReq", 32'(sReq), 32'd1);
    chk("rw firstAddr", sAddr, 32'h0);
    got = 0;
    cyc = 0;
    while (cyc < 10 && got < 1) begin
      memCycle(0, 1, 1);
      if (sDeq) begin
        chk("rw firstPC", sPC, 32'h0);
        chk("rw firstInsn", sInsn, 32'hA0);
        got++;
      end
      cyc++;
    end
    chk("rw firstSeen", 32'(got), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
